// File: rtl/sram_pkg.sv
// Shared types and constants for the MAC operand SRAM controller.
// Phase states, array geometry and counter sizing helpers.
package sram_pkg;

  localparam int SRAM_DEPTH  = 8;
  localparam int SRAM_ADDR_W = 4;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    ERR
  } sram_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sram_if.sv
// Request/response handshake between the MAC sequencer and the
// SRAM controller.
interface sram_if
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int ADDR_W = SRAM_ADDR_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing each SRAM strobe phase.
// Flags the last cycle (zero) and the one before it (one).
module sram_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// Single-word initiator for the async operand SRAM: sequences
// setup/pulse/hold strobe phases from registered outputs only.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DEPTH     = SRAM_DEPTH,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_if.slave             bus,
  output logic              Cs_n,
  output logic              We_n,
  output logic              Oe_n,
  output logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] IO
);

  localparam int MAXC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int CW   = cnt_w(MAXC);

  sram_state_e       state;
  logic              write_q;
  logic              drive_en;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              in_range;
  logic              load;
  logic [CW-1:0]     load_val;
  logic              zero;
  logic              one;

  assign accept   = bus.req_valid && bus.req_ready;
  assign in_range = 32'(bus.req_addr) < 32'(DEPTH);

  always_comb begin
    load     = 1'b0;
    load_val = '0;
    unique case (1'b1)
      state == IDLE: begin
        load     = accept;
        load_val = CW'(SETUP_CYC - 1);
      end
      state == SETUP: begin
        load     = zero;
        load_val = CW'(PULSE_CYC - 1);
      end
      state == ACTIVE: begin
        load     = zero;
        load_val = CW'(HOLD_CYC - 1);
      end
      default: ;
    endcase
  end

  sram_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (zero),
    .one      (one)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      Cs_n          <= 1'b1;
      We_n          <= 1'b1;
      Oe_n          <= 1'b1;
      Address       <= '0;
      drive_en      <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.req_ready <= 1'b0;
            if (in_range) begin
              state    <= SETUP;
              write_q  <= bus.req_write;
              wdata_q  <= bus.req_wdata;
              Address  <= bus.req_addr;
              Cs_n     <= 1'b0;
              Oe_n     <= bus.req_write;
              drive_en <= bus.req_write;
            end else begin
              state         <= ERR;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (zero) begin
            state <= ACTIVE;
            We_n  <= ~write_q;
          end
        end
        ACTIVE: begin
          if (zero) begin
            state         <= HOLD;
            We_n          <= 1'b1;
            Oe_n          <= 1'b1;
            bus.rsp_valid <= (HOLD_CYC == 1);
            if (!write_q) bus.rsp_rdata <= IO;
          end
        end
        HOLD: begin
          if (zero) begin
            state         <= IDLE;
            Cs_n          <= 1'b1;
            drive_en      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end else begin
            bus.rsp_valid <= one;
          end
        end
        ERR: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write data only reaches the bus behind a flop-driven enable.
  assign IO = drive_en ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: default-timing and 3/4/2-timing instances,
// each on its own behavioural async SRAM with a pulled-up bus.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscmp  = 0;

  bit          sel = 1'b0;
  logic        rq_valid = 1'b0;
  logic        rq_write = 1'b0;
  logic [3:0]  rq_addr  = '0;
  logic [15:0] rq_wdata = '0;

  sram_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
  sram_if #(.DATA_W(16), .ADDR_W(4)) if1 ();

  assign if0.req_valid = rq_valid && !sel;
  assign if0.req_write = rq_write;
  assign if0.req_addr  = rq_addr;
  assign if0.req_wdata = rq_wdata;
  assign if1.req_valid = rq_valid && sel;
  assign if1.req_write = rq_write;
  assign if1.req_addr  = rq_addr;
  assign if1.req_wdata = rq_wdata;

  logic       cs0, we0, oe0, cs1, we1, oe1;
  logic [3:0] ad0, ad1;
  wire [15:0] io0;
  wire [15:0] io1;

  pullup (io0);
  pullup (io1);

  sram_ctrl u0 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if0),
    .Cs_n    (cs0),
    .We_n    (we0),
    .Oe_n    (oe0),
    .Address (ad0),
    .IO      (io0)
  );

  sram_ctrl #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)) u1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (if1),
    .Cs_n    (cs1),
    .We_n    (we1),
    .Oe_n    (oe1),
    .Address (ad1),
    .IO      (io1)
  );

  logic [15:0] mem0 [16] = '{default: 16'h0};
  logic [15:0] mem1 [16] = '{default: 16'h0};

  assign io0 = (!cs0 && !oe0) ? mem0[ad0] : 16'hzzzz;
  assign io1 = (!cs1 && !oe1) ? mem1[ad1] : 16'hzzzz;
  always @(posedge we0) if (!cs0) mem0[ad0] <= io0;
  always @(posedge we1) if (!cs1) mem1[ad1] <= io1;

  wire        m_rdy = sel ? if1.req_ready : if0.req_ready;
  wire        m_rv  = sel ? if1.rsp_valid : if0.rsp_valid;
  wire        m_err = sel ? if1.rsp_err   : if0.rsp_err;
  wire [15:0] m_rd  = sel ? if1.rsp_rdata : if0.rsp_rdata;
  wire        m_cs  = sel ? cs1 : cs0;
  wire        m_we  = sel ? we1 : we0;
  wire        m_oe  = sel ? oe1 : oe0;
  wire [3:0]  m_ad  = sel ? ad1 : ad0;
  wire [15:0] m_io  = sel ? io1 : io0;

  logic [15:0] ref_mem [2][16] = '{default: '{default: 16'h0}};
  logic [15:0] ref_rd  [2]     = '{default: 16'h0};

  localparam logic [15:0] BUS_IDLE = 16'hFFFF;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!m_rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = m_rdy;
    chk("accept_wait", 32'(m_rdy), 32'd1);
  endtask

  task automatic txn(input logic w, input logic [3:0] a,
                     input logic [15:0] d);
    int s, p, h, len;
    bit ok, good;
    logic [5:0] ev, ov;
    logic [15:0] exp_rd;
    s = sel ? 3 : 1;
    p = sel ? 4 : 2;
    h = sel ? 2 : 1;
    good = (a < 4'd8);
    len = good ? s + p + h : 1;
    rq_write = w;
    rq_addr  = a;
    rq_wdata = d;
    rq_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      rq_valid = 1'b0;
      return;
    end
    if (good && w) ref_mem[sel][a] = d;
    if (good && !w) ref_rd[sel] = ref_mem[sel][a];
    exp_rd = ref_rd[sel];
    @(negedge clk);
    rq_valid = 1'b0;
    for (int k = 1; k <= len + 1; k++) begin
      if (k > len)       ev = 6'b111100;
      else if (!good)    ev = 6'b011111;
      else if (k <= s)   ev = {1'b0, 1'b0, 1'b1, w, 2'b00};
      else if (k <= s+p) ev = {1'b0, 1'b0, !w, w, 2'b00};
      else               ev = {4'b0011, (k == len), 1'b0};
      ov = {m_rdy, m_cs, m_we, m_oe, m_rv, m_err};
      chk($sformatf("strobes a=%0d w=%0b k=%0d", a, w, k), 32'(ov), 32'(ev));
      if (good && w && k <= len)
        chk($sformatf("io_wdata k=%0d", k), 32'(m_io), 32'(d));
      else if (k > len || !good || k > s + p)
        chk($sformatf("io_hiz k=%0d", k), 32'(m_io), 32'(BUS_IDLE));
      if (good && k == 1)
        chk("address", 32'(m_ad), 32'(a));
      if (k == len)
        chk($sformatf("rdata a=%0d", a), 32'(m_rd), 32'(exp_rd));
      if (k <= len) @(negedge clk);
    end
  endtask

  task automatic b2b();
    int last;
    bit ok;
    last = 0;
    rq_valid = 1'b1;
    rq_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rq_addr  = 4'(i);
      rq_wdata = 16'h1000 + 16'(i);
      wait_ready(ok);
      if (!ok) break;
      if (i > 0) begin
        chk("b2b_gap", 32'(cyc - last), 32'd5);
        chk("b2b_turn_cs", 32'(m_cs), 32'd1);
      end
      last = cyc;
      ref_mem[0][i] = 16'h1000 + 16'(i);
      @(negedge clk);
      chk("b2b_busy", 32'({m_rdy, m_cs}), 32'd0);
    end
    rq_valid = 1'b0;
  endtask

  task automatic reset_mid_op();
    bit ok;
    rq_write = 1'b1;
    rq_addr  = 4'd5;
    rq_wdata = 16'hAAAA;
    rq_valid = 1'b1;
    wait_ready(ok);
    @(negedge clk);
    rq_valid = 1'b0;
    @(negedge clk);
    chk("midop_we_low", 32'(m_we), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_strobes", 32'({m_cs, m_we, m_oe, m_rv}), 32'b1110);
    chk("midop_io_hiz", 32'(m_io), 32'(BUS_IDLE));
    rst = 1'b0;
    ref_rd[0] = 16'h0;
    ref_rd[1] = 16'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midop_no_rsp", 32'({m_rv, m_cs}), 32'b01);
    end
    chk("midop_rdata_clr", 32'(m_rd), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = bit'(i);
      #1;
      chk("reset_ctl", 32'({m_rdy, m_cs, m_we, m_oe, m_rv, m_err}),
          32'b111100);
      chk("reset_addr", 32'(m_ad), 32'd0);
      chk("reset_rdata", 32'(m_rd), 32'd0);
      chk("reset_io", 32'(m_io), 32'(BUS_IDLE));
    end
    sel = 1'b0;
    @(negedge clk);

    txn(1'b1, 4'd3, 16'h3C00);
    txn(1'b0, 4'd3, 16'h0);

    b2b();
    for (int i = 0; i < 8; i++) txn(1'b0, 4'(i), 16'h0);

    txn(1'b0, 4'd9, 16'h0);
    txn(1'b1, 4'd15, 16'hFFFF);
    txn(1'b0, 4'd7, 16'h0);

    for (int i = 0; i < 24; i++)
      txn(1'($urandom_range(1, 0)), 4'($urandom_range(9, 0)),
          16'($urandom_range(16'hFFFE, 0)));

    reset_mid_op();
    txn(1'b1, 4'd5, 16'h4248);
    txn(1'b0, 4'd5, 16'h0);

    sel = 1'b1;
    @(negedge clk);
    txn(1'b1, 4'd2, 16'hBEEF);
    txn(1'b0, 4'd2, 16'h0);
    txn(1'b0, 4'd12, 16'h0);
    for (int i = 0; i < 12; i++)
      txn(1'($urandom_range(1, 0)), 4'($urandom_range(9, 0)),
          16'($urandom_range(16'hFFFE, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
